// File: rtl/fetch_sequencer.sv
// Program-counter sequencer driving the instruction ROM address.
// Handles sequential fetch, jumps, relative branches, stalls, halts and a one-cycle redirect bubble.
module fetch_sequencer #(
    parameter int unsigned IW  = 4,
    parameter int unsigned PCW = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [PCW-1:0] start_addr,
    input  logic           stall,
    input  logic           jump,
    input  logic [PCW-1:0] jump_target,
    input  logic           branch_taken,
    input  logic [PCW-1:0] branch_offset,
    input  logic           halt_req,
    output logic [PCW-1:0] pc,
    output logic           fetch_valid,
    output logic           running,
    output logic           done,
    output logic           fault,
    output logic [15:0]    cycle_count,
    output logic [15:0]    instr_count
);

    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [PCW-1:0] pc_n;
    logic [PCW-1:0] pc_cand;
    logic           redirect;
    logic           done_n;
    logic           fault_n;
    logic [CW-1:0]  cycle_n;
    logic [CW-1:0]  instr_n;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + CW'(1);
    endfunction

    function automatic logic out_of_range(input logic [PCW-1:0] v);
        return v[PCW-1:IW] != '0;
    endfunction

    // Candidate PC for an accepted instruction, lowest priority last
    always_comb begin
        pc_cand  = pc + PCW'(1);
        redirect = 1'b0;
        if (jump) begin
            pc_cand  = jump_target;
            redirect = 1'b1;
        end else if (branch_taken) begin
            pc_cand  = pc + branch_offset;
            redirect = 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        done_n  = 1'b0;
        fault_n = fault;
        cycle_n = cycle_count;
        instr_n = instr_count;

        if (state == RUN || state == FLUSH) begin
            cycle_n = sat_inc(cycle_count);
        end

        unique case (state)
            IDLE, HALTED: begin
                if (start) begin
                    cycle_n = '0;
                    instr_n = '0;
                    pc_n    = start_addr;
                    if (out_of_range(start_addr)) begin
                        state_n = HALTED;
                        fault_n = 1'b1;
                        done_n  = 1'b1;
                    end else begin
                        state_n = RUN;
                        fault_n = 1'b0;
                    end
                end
            end
            RUN: begin
                if (!stall) begin
                    instr_n = sat_inc(instr_count);
                    if (halt_req) begin
                        state_n = HALTED;
                        done_n  = 1'b1;
                    end else begin
                        pc_n = pc_cand;
                        if (out_of_range(pc_cand)) begin
                            state_n = HALTED;
                            fault_n = 1'b1;
                            done_n  = 1'b1;
                        end else if (redirect) begin
                            state_n = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                state_n = RUN;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            done        <= 1'b0;
            fault       <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            done        <= done_n;
            fault       <= fault_n;
            cycle_count <= cycle_n;
            instr_count <= instr_n;
        end
    end

    // Status decoded straight from the state register
    assign fetch_valid = (state == RUN);
    assign running     = (state == RUN) || (state == FLUSH);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  start_addr;
    logic        stall;
    logic        jump;
    logic [7:0]  jump_target;
    logic        branch_taken;
    logic [7:0]  branch_offset;
    logic        halt_req;
    logic [7:0]  pc;
    logic        fetch_valid;
    logic        running;
    logic        done;
    logic        fault;
    logic [15:0] cycle_count;
    logic [15:0] instr_count;

    int compared   = 0;
    int mismatched = 0;

    fetch_sequencer #(.IW(4), .PCW(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .start_addr   (start_addr),
        .stall        (stall),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .halt_req     (halt_req),
        .pc           (pc),
        .fetch_valid  (fetch_valid),
        .running      (running),
        .done         (done),
        .fault        (fault),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got no end want end");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [7:0] a);
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1;
        start_addr = a;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; start_addr = 0; stall = 0; jump = 0; jump_target = 0;
        branch_taken = 0; branch_offset = 0; halt_req = 0;
        step(); step();
        reset = 1'b0;
        step();
        compared++;
        if (pc !== 8'd0 || fetch_valid !== 1'b0 || running !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin
            $display("FAIL reset_outputs got pc=%0d fv=%b run=%b done=%b fault=%b want 0/0/0/0/0",
                     pc, fetch_valid, running, done, fault);
            mismatched++;
        end
        compared++;
        if (cycle_count !== 16'd0 || instr_count !== 16'd0) begin
            $display("FAIL reset_counters got cc=%0d ic=%0d want 0/0", cycle_count, instr_count);
            mismatched++;
        end
    endtask

    task automatic test_runoff();
        start = 1'b1; start_addr = 8'd0;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            compared++;
            if (pc !== 8'(i) || fetch_valid !== 1'b1) begin
                $display("FAIL runoff_seq got pc=%0d fv=%b want pc=%0d fv=1", pc, fetch_valid, i);
                mismatched++;
            end
            step();
        end
        compared++;
        if (pc !== 8'd16 || fault !== 1'b1 || done !== 1'b1 || running !== 1'b0) begin
            $display("FAIL runoff_halt got pc=%0d fault=%b done=%b run=%b want 16/1/1/0",
                     pc, fault, done, running);
            mismatched++;
        end
        compared++;
        if (instr_count !== 16'd16 || cycle_count !== 16'd16) begin
            $display("FAIL runoff_counts got ic=%0d cc=%0d want 16/16", instr_count, cycle_count);
            mismatched++;
        end
        step();
        compared++;
        if (done !== 1'b0 || fault !== 1'b1 || pc !== 8'd16) begin
            $display("FAIL runoff_hold got done=%b fault=%b pc=%0d want 0/1/16", done, fault, pc);
            mismatched++;
        end
    endtask

    task automatic test_jump();
        restart(8'd0);
        step(); step(); step();
        jump = 1'b1; jump_target = 8'd10;
        step();
        jump = 1'b0;
        compared++;
        if (pc !== 8'd10 || fetch_valid !== 1'b0 || running !== 1'b1) begin
            $display("FAIL jump_bubble got pc=%0d fv=%b run=%b want 10/0/1", pc, fetch_valid, running);
            mismatched++;
        end
        step();
        compared++;
        if (pc !== 8'd10 || fetch_valid !== 1'b1 || instr_count !== 16'd4 || cycle_count !== 16'd5) begin
            $display("FAIL jump_valid got pc=%0d fv=%b ic=%0d cc=%0d want 10/1/4/5",
                     pc, fetch_valid, instr_count, cycle_count);
            mismatched++;
        end
        // start while running is ignored and the instruction still advances
        start = 1'b1; start_addr = 8'd2;
        step();
        start = 1'b0;
        compared++;
        if (pc !== 8'd11 || instr_count !== 16'd5) begin
            $display("FAIL jump_start_ignored got pc=%0d ic=%0d want 11/5", pc, instr_count);
            mismatched++;
        end
    endtask

    task automatic test_branch();
        restart(8'd0);
        for (int i = 0; i < 8; i++) step();
        branch_taken = 1'b1; branch_offset = 8'hFB;
        step();
        branch_taken = 1'b0;
        compared++;
        if (pc !== 8'd3 || fetch_valid !== 1'b0) begin
            $display("FAIL branch_bubble got pc=%0d fv=%b want 3/0", pc, fetch_valid);
            mismatched++;
        end
        step();
        compared++;
        if (pc !== 8'd3 || fetch_valid !== 1'b1) begin
            $display("FAIL branch_valid got pc=%0d fv=%b want 3/1", pc, fetch_valid);
            mismatched++;
        end
        step();
        compared++;
        if (pc !== 8'd4) begin
            $display("FAIL branch_seq got pc=%0d want 4", pc);
            mismatched++;
        end
        jump = 1'b1; jump_target = 8'd12; branch_taken = 1'b1; branch_offset = 8'd2;
        step();
        jump = 1'b0; branch_taken = 1'b0;
        compared++;
        if (pc !== 8'd12 || fetch_valid !== 1'b0) begin
            $display("FAIL branch_jump_prio got pc=%0d fv=%b want 12/0", pc, fetch_valid);
            mismatched++;
        end
        step(); step();
        compared++;
        if (pc !== 8'd13 || fetch_valid !== 1'b1) begin
            $display("FAIL branch_after_prio got pc=%0d fv=%b want 13/1", pc, fetch_valid);
            mismatched++;
        end
    endtask

    task automatic test_stall();
        restart(8'd0);
        for (int i = 0; i < 5; i++) step();
        stall = 1'b1; jump = 1'b1; jump_target = 8'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            compared++;
            if (pc !== 8'd5 || fetch_valid !== 1'b1) begin
                $display("FAIL stall_hold got pc=%0d fv=%b want 5/1", pc, fetch_valid);
                mismatched++;
            end
        end
        compared++;
        if (cycle_count !== 16'd8 || instr_count !== 16'd5) begin
            $display("FAIL stall_counts got cc=%0d ic=%0d want 8/5", cycle_count, instr_count);
            mismatched++;
        end
        stall = 1'b0;
        step();
        jump = 1'b0;
        compared++;
        if (pc !== 8'd9 || fetch_valid !== 1'b0 || instr_count !== 16'd6 || cycle_count !== 16'd9) begin
            $display("FAIL stall_release got pc=%0d fv=%b ic=%0d cc=%0d want 9/0/6/9",
                     pc, fetch_valid, instr_count, cycle_count);
            mismatched++;
        end
    endtask

    task automatic test_halt_restart();
        restart(8'd0);
        for (int i = 0; i < 6; i++) step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        compared++;
        if (pc !== 8'd6 || done !== 1'b1 || fault !== 1'b0 || running !== 1'b0 || fetch_valid !== 1'b0) begin
            $display("FAIL halt_entry got pc=%0d done=%b fault=%b run=%b fv=%b want 6/1/0/0/0",
                     pc, done, fault, running, fetch_valid);
            mismatched++;
        end
        compared++;
        if (instr_count !== 16'd7 || cycle_count !== 16'd7) begin
            $display("FAIL halt_counts got ic=%0d cc=%0d want 7/7", instr_count, cycle_count);
            mismatched++;
        end
        step(); step();
        compared++;
        if (done !== 1'b0 || pc !== 8'd6 || cycle_count !== 16'd7) begin
            $display("FAIL halt_hold got done=%b pc=%0d cc=%0d want 0/6/7", done, pc, cycle_count);
            mismatched++;
        end
        start = 1'b1; start_addr = 8'd2;
        step();
        start = 1'b0;
        compared++;
        if (pc !== 8'd2 || fetch_valid !== 1'b1 || instr_count !== 16'd0 || cycle_count !== 16'd0) begin
            $display("FAIL halt_restart got pc=%0d fv=%b ic=%0d cc=%0d want 2/1/0/0",
                     pc, fetch_valid, instr_count, cycle_count);
            mismatched++;
        end
    endtask

    task automatic test_bad_start_async_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b1; start_addr = 8'h20;
        step();
        start = 1'b0;
        compared++;
        if (pc !== 8'h20 || fault !== 1'b1 || done !== 1'b1 || running !== 1'b0 || fetch_valid !== 1'b0) begin
            $display("FAIL bad_start got pc=%0h fault=%b done=%b run=%b fv=%b want 20/1/1/0/0",
                     pc, fault, done, running, fetch_valid);
            mismatched++;
        end
        step();
        compared++;
        if (done !== 1'b0 || fault !== 1'b1) begin
            $display("FAIL bad_start_hold got done=%b fault=%b want 0/1", done, fault);
            mismatched++;
        end
        restart(8'd0);
        step(); step(); step();
        #2;
        reset = 1'b1;
        #1;
        compared++;
        if (pc !== 8'd0 || running !== 1'b0 || fetch_valid !== 1'b0 ||
            cycle_count !== 16'd0 || instr_count !== 16'd0) begin
            $display("FAIL async_reset got pc=%0d run=%b fv=%b cc=%0d ic=%0d want 0/0/0/0/0",
                     pc, running, fetch_valid, cycle_count, instr_count);
            mismatched++;
        end
        step();
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_runoff();
        test_jump();
        test_branch();
        test_stall();
        test_halt_restart();
        test_bad_start_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
